membus_arbiter: RTL
===================

# membus_arbiter

Shares one single-beat memory port between the core's instruction bus (fetch stage) and data bus (memory stage). It accepts at most one transaction at a time, sequences it through the address and data handshakes of the shared port, and returns the response to the winning requester. It sits between `MyCore` and the memory/cache side.

## Interface
Parameters
- None. Widths are fixed by `common.svh`: 32-bit address and data, 4-bit strobe, 3-bit size.

Ports
- `clk  in  1` — clock.
- `resetn  in  1` — reset, asynchronous, **active-high** despite the name. Asserted (1) forces reset state immediately.
- `ireq  in  ibus_req_t` — instruction request; uses `valid` and `addr`.
- `iresp  out  ibus_resp_t` — `addr_ok`, `data_ok`, `data`.
- `dreq  in  dbus_req_t` — data request; uses `valid`, `addr`, `size`, `strobe`, `data`. Write iff `strobe != 0`.
- `dresp  out  dbus_resp_t` — `addr_ok`, `data_ok`, `data`.
- `m_valid  out  1` — shared-port request valid.
- `m_addr  out  32` — request address.
- `m_size  out  3` — request size. Ibus transactions always drive `MSIZE4`.
- `m_strobe  out  4` — byte strobe. Zero means read; ibus transactions always drive 0.
- `m_wdata  out  32` — write data.
- `m_addr_ok  in  1` — memory accepted the address this cycle.
- `m_data_ok  in  1` — memory completed the transaction this cycle.
- `m_rdata  in  32` — read data, valid when `m_data_ok` is high.

## Operation
States: `IDLE`, `REQ`, `WAIT`. A `grant` register (I/D) and a `last` register (I/D) are kept alongside the state.

- **IDLE — arbitration**
  - Only dbus valid → grant D.
  - Only ibus valid → grant I.
  - Both valid → grant the requester that is not `last`.
  - On a grant: latch the request fields, pulse the winner's `addr_ok` for this cycle, set `last := winner`, go to `REQ`.
  - Neither valid → stay in `IDLE`.
- **REQ**
  - Drive `m_valid=1` with the latched fields; the requester's live inputs are ignored.
  - `m_addr_ok & m_data_ok` → winner's `data_ok=1`, `data=m_rdata` (combinational), go to `IDLE`.
  - `m_addr_ok` only → go to `WAIT`.
  - Neither → stay in `REQ`.
- **WAIT**
  - `m_valid=0`.
  - `m_data_ok` → winner's `data_ok=1`, `data=m_rdata`, go to `IDLE`.
- **Outputs to requesters**
  - The loser's `addr_ok` and `data_ok` are always 0.
  - Both `data` fields are 0 except in a `data_ok` cycle.
  - `addr_ok` and `data_ok` never assert together on the same requester.
- **Fairness**
  - With both requesters continuously valid, grants strictly alternate D, I, D, I, ...
  - Neither requester can starve.
- **Spurious response:** `m_data_ok` while in `IDLE` or `REQ` without `m_addr_ok` is a protocol error. It is ignored: no requester `data_ok`.

## Timing
- **Reset values** (while `resetn=1`)
  - State `IDLE`; `last=I`, so D wins the first tie.
  - `m_valid=0`; `m_addr`, `m_size`, `m_strobe`, `m_wdata` = 0.
  - `iresp` and `dresp` all-zero.
- **Reset mid-transaction:** abandons it with no `data_ok` to either side. The memory is reset by the same `resetn`.
- **Latency**
  - Requester `addr_ok` in cycle T, the cycle `valid` is seen in `IDLE`.
  - `m_valid` first high at T+1.
  - Earliest requester `data_ok` at T+1, when memory returns `addr_ok` and `data_ok` together.
  - Next grant no earlier than the cycle after `data_ok`: one `IDLE` cycle between transactions.
- **Requester hold rule:** a requester may drop `valid` or change fields after its `addr_ok` cycle. It must not issue another request until it has seen its `data_ok`.
- **Handshakes:** `m_valid` stays high with stable fields from entering `REQ` until `m_addr_ok`.

## Structure
- Shared package (`common.svh`):
  - `typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t`
  - `typedef enum logic {GNT_I, GNT_D} arb_grant_t`
- Single module; no sub-module needed. The latched request is one packed register, loaded only in `IDLE` on a grant.

## Test plan
- **Reset:** assert `resetn` in `REQ` with `m_valid=1` → `m_valid` drops immediately; after release, state is `IDLE` and all outputs are 0.
- **Ibus read:** ibus-only read addr `0xbfc0_0000`, memory answers `addr_ok` at T+1 and `data_ok`/`0x2408_0001` at T+3 → `iresp.addr_ok` at T, `iresp.data_ok` with `0x2408_0001` at T+3, `dresp` silent throughout.
- **Dbus write:** dbus write addr `0x8000_0010`, `strobe=4'b0011`, data `0x1234_5678`, memory `addr_ok & data_ok` at T+1 → `m_strobe=0011`, `m_wdata=0x1234_5678` at T+1, `dresp.data_ok` at T+1.
- **Tie:** both valid from reset → D granted first, then I on the next `IDLE`; with both held valid, grant order D, I, D, I over 4 transactions.
- **Back-pressure:** `m_addr_ok` held low 5 cycles in `REQ` while the ibus `addr` input changes → `m_addr` stays at the latched value and `m_valid` stays high for all 5 cycles.
- **Spurious response:** `m_data_ok` pulsed in `IDLE` → no requester `data_ok`, state unchanged.

Source files
------------

// File: rtl/membus_arbiter_pkg.sv
// membus_arbiter_pkg
//   Bus request/response types shared by the core and the memory-port
//   arbiter, plus the arbiter's state and grant encodings.
package membus_arbiter_pkg;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  // Request fields captured at grant time and replayed on the shared port.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
  } mreq_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_grant_t;

endpackage

// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Shares one single-beat memory port between the instruction bus and the
//   data bus. One transaction in flight at a time; ties alternate.
// Ports
//   clk, resetn          clock; resetn is asynchronous and active-high
//   ireq / iresp         instruction bus request / response
//   dreq / dresp         data bus request / response (write iff strobe != 0)
//   m_valid .. m_wdata   shared-port request
//   m_addr_ok, m_data_ok, m_rdata   shared-port handshakes and read data
module membus_arbiter
  import membus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  arb_state_t state;
  arb_grant_t grant;
  arb_grant_t last;
  mreq_t      held;

  arb_grant_t winner;
  logic       anyValid;
  logic       addrOk;
  logic       dataOk;

  assign anyValid = ireq.valid | dreq.valid;

  always_comb begin
    winner = GNT_I;
    if (ireq.valid && dreq.valid)
      winner = (last == GNT_I) ? GNT_D : GNT_I;
    else if (dreq.valid)
      winner = GNT_D;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
      grant <= GNT_I;
      last  <= GNT_I;
      held  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            grant <= winner;
            last  <= winner;
            if (winner == GNT_D)
              held <= '{addr: dreq.addr, size: dreq.size,
                        strobe: dreq.strobe, wdata: dreq.data};
            else
              held <= '{addr: ireq.addr, size: MSIZE4,
                        strobe: '0, wdata: '0};
            state <= REQ;
          end
        end
        REQ: begin
          if (m_addr_ok)
            state <= m_data_ok ? IDLE : WAIT;
        end
        WAIT: begin
          if (m_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_valid  = (state == REQ);
  assign m_addr   = held.addr;
  assign m_size   = held.size;
  assign m_strobe = held.strobe;
  assign m_wdata  = held.wdata;

  // Responses are forced silent while reset is held, since IDLE with a
  // valid request would otherwise pulse addr_ok during reset.
  assign addrOk = !resetn && (state == IDLE) && anyValid;
  assign dataOk = !resetn && (((state == REQ) && m_addr_ok && m_data_ok) ||
                              ((state == WAIT) && m_data_ok));

  always_comb begin
    iresp = '0;
    dresp = '0;
    if (addrOk) begin
      if (winner == GNT_D) dresp.addr_ok = 1'b1;
      else                 iresp.addr_ok = 1'b1;
    end
    if (dataOk) begin
      if (grant == GNT_D) begin
        dresp.data_ok = 1'b1;
        dresp.data    = m_rdata;
      end else begin
        iresp.data_ok = 1'b1;
        iresp.data    = m_rdata;
      end
    end
  end

endmodule
